// File: rtl/rs_hang_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rs_hang_scheduler_pkg
// Description : Shared types and constants for the link hang scheduler:
//               scheduler state encoding, LFSR tap mask, percentage scale,
//               requester index width and the LFSR step function.
// Revision    : 1.0 - initial release
// ============================================================================
package rs_hang_scheduler_pkg;

    // Scheduler states. IDLE is the only state in which decisions are made.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HANG = 2'd1,
        GAP  = 2'd2
    } sched_state_t;

    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: the feedback
    // is the XOR of bits 0, 2, 3 and 5 and enters at bit 15.
    localparam logic [15:0] c_LFSR_TAPS    = 16'h002D;

    // Rolls are taken modulo this value, giving a percentage in 0..99.
    localparam logic [15:0] c_CHANCE_SCALE = 16'd100;

    // Width of a requester index (covers up to 32 links).
    localparam int          c_ID_W         = 5;

    // One LFSR step.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {^(cur & c_LFSR_TAPS), cur[15:1]};
    endfunction

endpackage : rs_hang_scheduler_pkg
`default_nettype wire

// File: rtl/rs_hang_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : rs_hang_scheduler_if
// Description : Bundle of configuration, request and decision signals between
//               the link fault injectors (master) and the hang scheduler
//               (slave).
//   enable_i      - scheduler enable; low aborts any hang
//   cfg_chance_i  - hang probability in percent (>=100 always hangs)
//   cfg_cycles_i  - hang duration in cycles (0 behaves as 1)
//   cfg_gap_i     - cooldown cycles after a hang
//   req_i         - level hang request per injector
//   hang_o        - one-hot-or-zero stall level per link
//   resp_valid_o  - one-cycle decision pulse
//   resp_id_o     - index of the decided requester
//   resp_hang_o   - decision: 1 = hang granted, 0 = skip
//   busy_o        - high while hanging or cooling down
//   hang_count_o  - hangs granted since reset (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
interface rs_hang_scheduler_if #(
    parameter int N_LINKS = 8
);
    import rs_hang_scheduler_pkg::*;

    logic                enable_i;
    logic [6:0]          cfg_chance_i;
    logic [31:0]         cfg_cycles_i;
    logic [15:0]         cfg_gap_i;
    logic [N_LINKS-1:0]  req_i;

    logic [N_LINKS-1:0]  hang_o;
    logic                resp_valid_o;
    logic [c_ID_W-1:0]   resp_id_o;
    logic                resp_hang_o;
    logic                busy_o;
    logic [15:0]         hang_count_o;

    // Injector / campaign side.
    modport master (
        output enable_i, cfg_chance_i, cfg_cycles_i, cfg_gap_i, req_i,
        input  hang_o, resp_valid_o, resp_id_o, resp_hang_o, busy_o,
               hang_count_o
    );

    // Scheduler side.
    modport slave (
        input  enable_i, cfg_chance_i, cfg_cycles_i, cfg_gap_i, req_i,
        output hang_o, resp_valid_o, resp_id_o, resp_hang_o, busy_o,
               hang_count_o
    );

endinterface : rs_hang_scheduler_if
`default_nettype wire

// File: rtl/rs_hang_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rs_hang_scheduler_rr_arbiter
// Description : Combinational round-robin pick. The winner is the first set
//               request bit at or above the pointer; if none, the lowest set
//               bit overall (wrap-around). The pointer register lives in the
//               scheduler.
//   i_req      - request vector
//   i_pointer  - current round-robin start index (< N)
//   o_winner   - index of the selected requester
//   o_valid    - at least one request is set
// Revision    : 1.0 - initial release
// ============================================================================
module rs_hang_scheduler_rr_arbiter
    import rs_hang_scheduler_pkg::*;
#(
    parameter int N = 8
) (
    input  wire logic [N-1:0]      i_req,
    input  wire logic [c_ID_W-1:0] i_pointer,
    output logic      [c_ID_W-1:0] o_winner,
    output logic                   o_valid
);

    logic              w_hi_found;
    logic [c_ID_W-1:0] w_hi_idx;
    logic              w_lo_found;
    logic [c_ID_W-1:0] w_lo_idx;

    // Scan from the top down so the last hit written is the lowest index.
    // "hi" only considers bits at/after the pointer; "lo" is the wrap case.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_found = 1'b0;
        w_lo_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_lo_found = 1'b1;
                w_lo_idx   = c_ID_W'(i);
                if (c_ID_W'(i) >= i_pointer) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = c_ID_W'(i);
                end
            end
        end
    end

    assign o_valid  = w_lo_found;
    assign o_winner = w_hi_found ? w_hi_idx : w_lo_idx;

endmodule : rs_hang_scheduler_rr_arbiter
`default_nettype wire

// File: rtl/rs_hang_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rs_hang_scheduler
// Description : Central scheduler for NoC link hang injection. Arbitrates
//               round-robin among injector requests, rolls a pseudo-random
//               percentage against cfg_chance_i, grants at most one hang at a
//               time, holds it for the latched duration and then enforces a
//               cooldown gap. The decision sequence is reproducible from SEED.
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset
//   bus     - rs_hang_scheduler_if.slave (config, requests, decisions, status)
// Revision    : 1.0 - initial release
// ============================================================================
module rs_hang_scheduler
    import rs_hang_scheduler_pkg::*;
#(
    parameter int          N_LINKS = 8,        // 2..32 requesters
    parameter logic [15:0] SEED    = 16'hACE1  // LFSR reset value, nonzero
) (
    input  wire logic           clk_i,
    input  wire logic           rst_ni,
    rs_hang_scheduler_if.slave  bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    sched_state_t        r_state_q,      w_state_d;
    logic [c_ID_W-1:0]   r_ptr_q,        w_ptr_d;
    logic [15:0]         r_lfsr_q,       w_lfsr_d;
    logic [31:0]         r_hang_cnt_q,   w_hang_cnt_d;
    logic [15:0]         r_gap_reg_q,    w_gap_reg_d;
    logic [15:0]         r_gap_cnt_q,    w_gap_cnt_d;
    logic [N_LINKS-1:0]  r_hang_q,       w_hang_d;
    logic                r_resp_valid_q, w_resp_valid_d;
    logic [c_ID_W-1:0]   r_resp_id_q,    w_resp_id_d;
    logic                r_resp_hang_q,  w_resp_hang_d;
    logic                r_busy_q,       w_busy_d;
    logic [15:0]         r_hang_count_q, w_hang_count_d;

    // ------------------------------------------------------------------
    // Arbitration and roll
    // ------------------------------------------------------------------
    logic [c_ID_W-1:0]   w_arb_winner;
    logic                w_arb_valid;
    logic [6:0]          w_roll;
    logic                w_chance_hit;
    logic [c_ID_W-1:0]   w_ptr_next;
    logic [31:0]         w_cycles_eff;
    logic [N_LINKS-1:0]  w_grant_vec;

    rs_hang_scheduler_rr_arbiter #(
        .N          (N_LINKS)
    ) u_rr_arbiter (
        .i_req      (bus.req_i),
        .i_pointer  (r_ptr_q),
        .o_winner   (w_arb_winner),
        .o_valid    (w_arb_valid)
    );

    // The roll is taken from the current LFSR value; since the LFSR is below
    // 2^16 the remainder always fits in 7 bits, and any chance >= 100 wins.
    assign w_roll       = 7'(r_lfsr_q % c_CHANCE_SCALE);
    assign w_chance_hit = (w_roll < bus.cfg_chance_i);

    assign w_ptr_next   = (w_arb_winner == c_ID_W'(N_LINKS - 1)) ? '0
                                                                 : w_arb_winner + c_ID_W'(1);

    // A zero duration still produces a one-cycle hang.
    assign w_cycles_eff = (bus.cfg_cycles_i == 32'd0) ? 32'd1 : bus.cfg_cycles_i;

    assign w_grant_vec  = {{(N_LINKS-1){1'b0}}, 1'b1} << w_arb_winner;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d      = r_state_q;
        w_ptr_d        = r_ptr_q;
        w_lfsr_d       = lfsr_next(r_lfsr_q);   // free-running in every state
        w_hang_cnt_d   = r_hang_cnt_q;
        w_gap_reg_d    = r_gap_reg_q;
        w_gap_cnt_d    = r_gap_cnt_q;
        w_hang_d       = r_hang_q;
        w_resp_valid_d = 1'b0;
        w_resp_id_d    = '0;
        w_resp_hang_d  = 1'b0;
        w_hang_count_d = r_hang_count_q;

        case (r_state_q)
            IDLE: begin
                if (bus.enable_i && w_arb_valid) begin
                    w_resp_valid_d = 1'b1;
                    w_resp_id_d    = w_arb_winner;
                    w_resp_hang_d  = w_chance_hit;
                    w_ptr_d        = w_ptr_next;
                    if (w_chance_hit) begin
                        // Config is captured here only; later changes are
                        // invisible to the running hang and its gap.
                        w_hang_cnt_d   = w_cycles_eff;
                        w_gap_reg_d    = bus.cfg_gap_i;
                        w_hang_d       = w_grant_vec;
                        w_hang_count_d = r_hang_count_q + 16'd1;
                        w_state_d      = HANG;
                    end
                end
            end

            HANG: begin
                if (!bus.enable_i) begin
                    // Abort skips the gap entirely.
                    w_hang_d  = '0;
                    w_state_d = IDLE;
                end else if (r_hang_cnt_q == 32'd1) begin
                    w_hang_d = '0;
                    if (r_gap_reg_q != 16'd0) begin
                        w_gap_cnt_d = r_gap_reg_q;
                        w_state_d   = GAP;
                    end else begin
                        w_state_d   = IDLE;
                    end
                end else begin
                    w_hang_cnt_d = r_hang_cnt_q - 32'd1;
                end
            end

            GAP: begin
                if (!bus.enable_i || (r_gap_cnt_q == 16'd1)) begin
                    w_state_d = IDLE;
                end else begin
                    w_gap_cnt_d = r_gap_cnt_q - 16'd1;
                end
            end

            default: begin
                w_hang_d  = '0;
                w_state_d = IDLE;
            end
        endcase

        w_busy_d = (w_state_d != IDLE);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q      <= IDLE;
            r_ptr_q        <= '0;
            r_lfsr_q       <= SEED;
            r_hang_cnt_q   <= '0;
            r_gap_reg_q    <= '0;
            r_gap_cnt_q    <= '0;
            r_hang_q       <= '0;
            r_resp_valid_q <= 1'b0;
            r_resp_id_q    <= '0;
            r_resp_hang_q  <= 1'b0;
            r_busy_q       <= 1'b0;
            r_hang_count_q <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_ptr_q        <= w_ptr_d;
            r_lfsr_q       <= w_lfsr_d;
            r_hang_cnt_q   <= w_hang_cnt_d;
            r_gap_reg_q    <= w_gap_reg_d;
            r_gap_cnt_q    <= w_gap_cnt_d;
            r_hang_q       <= w_hang_d;
            r_resp_valid_q <= w_resp_valid_d;
            r_resp_id_q    <= w_resp_id_d;
            r_resp_hang_q  <= w_resp_hang_d;
            r_busy_q       <= w_busy_d;
            r_hang_count_q <= w_hang_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all straight from flops)
    // ------------------------------------------------------------------
    assign bus.hang_o       = r_hang_q;
    assign bus.resp_valid_o = r_resp_valid_q;
    assign bus.resp_id_o    = r_resp_id_q;
    assign bus.resp_hang_o  = r_resp_hang_q;
    assign bus.busy_o       = r_busy_q;
    assign bus.hang_count_o = r_hang_count_q;

endmodule : rs_hang_scheduler
`default_nettype wire

// File: tb/tb_rs_hang_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_hang_scheduler
// Description : Self-checking bench for rs_hang_scheduler. A timeline model
//               (decision edge, hang end, busy end) predicts every output on
//               every cycle; directed tests add hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_hang_scheduler;

    localparam int          N    = 8;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    rs_hang_scheduler_if #(.N_LINKS(N)) bus ();

    rs_hang_scheduler #(
        .N_LINKS (N),
        .SEED    (SEED)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Timeline model. Edge numbers count clock edges since reset release.
    // A granted hang at edge d with duration D and gap G keeps hang_o high
    // after edges d..d+D-1 and busy_o high after edges d..d+D+G-1; the
    // scheduler is occupied at edges d+1..d+D+G and may decide again later.
    // Disabling at an occupied edge a truncates both windows to end at a.
    // ------------------------------------------------------------------
    initial begin : model_proc
        longint          cyc;
        logic [15:0]     m_lfsr;
        int              m_ptr;
        logic            m_active;
        longint          m_hang_end;
        longint          m_busy_end;
        int              m_hang_id;
        logic [15:0]     m_count;
        logic            ev;
        logic [4:0]      eid;
        logic            eh;
        logic [N-1:0]    ehv;
        logic            eb;
        logic [N-1:0]    r;
        int              w;
        int              j;
        int              roll;
        longint          dur;
        logic            fb;

        cyc = 0; m_lfsr = SEED; m_ptr = 0; m_active = 0; m_hang_end = 0;
        m_busy_end = 0; m_hang_id = 0; m_count = 0; ev = 0; eid = 0; eh = 0;
        forever begin
            @(posedge clk_i);
            #1;
            ev = 0; eid = 0; eh = 0;
            if (!rst_ni) begin
                cyc = 0; m_lfsr = SEED; m_ptr = 0; m_active = 0;
                m_hang_end = 0; m_busy_end = 0; m_hang_id = 0; m_count = 0;
            end else begin
                cyc++;
                r = bus.req_i;
                if (m_active && cyc <= m_busy_end) begin
                    if (!bus.enable_i) begin
                        m_busy_end = cyc;
                        if (m_hang_end > cyc) m_hang_end = cyc;
                    end
                end else if (bus.enable_i && r != '0) begin
                    w = -1;
                    for (int i = 0; i < N; i++) begin
                        j = (m_ptr + i) % N;
                        if (w < 0 && r[j]) w = j;
                    end
                    roll = int'(m_lfsr) % 100;
                    ev   = 1'b1;
                    eid  = 5'(w);
                    eh   = (roll < int'(bus.cfg_chance_i));
                    m_ptr = (w + 1) % N;
                    if (eh) begin
                        dur = longint'(bus.cfg_cycles_i);
                        if (dur == 0) dur = 1;
                        m_active   = 1'b1;
                        m_hang_id  = w;
                        m_hang_end = cyc + dur;
                        m_busy_end = cyc + dur + longint'(bus.cfg_gap_i);
                        m_count    = m_count + 16'd1;
                    end
                end
                fb     = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
                m_lfsr = (m_lfsr >> 1) | (16'(fb) << 15);
            end
            ehv = '0;
            if (m_active && cyc < m_hang_end) ehv[m_hang_id] = 1'b1;
            eb = m_active && (cyc < m_busy_end);
            chk("m_resp_valid", bus.resp_valid_o, ev);
            chk("m_resp_id",    bus.resp_id_o,    eid);
            chk("m_resp_hang",  bus.resp_hang_o,  eh);
            chk("m_hang_o",     bus.hang_o,       ehv);
            chk("m_busy",       bus.busy_o,       eb);
            chk("m_hang_count", bus.hang_count_o, m_count);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change on falling edges only)
    // ------------------------------------------------------------------
    task automatic set_cfg(input logic [6:0] ch, input logic [31:0] cy, input logic [15:0] gp);
        bus.cfg_chance_i = ch;
        bus.cfg_cycles_i = cy;
        bus.cfg_gap_i    = gp;
    endtask

    // Leaves the caller on the falling edge at which reset is released.
    task automatic do_reset();
        @(negedge clk_i);
        rst_ni         = 1'b0;
        bus.req_i      = '0;
        bus.enable_i   = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic wait_resp(input int budget, input string name,
                             output logic ok, output logic [4:0] id, output logic h);
        ok = 1'b0; id = '0; h = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk_i);
            if (bus.resp_valid_o) begin
                ok = 1'b1;
                id = bus.resp_id_o;
                h  = bus.resp_hang_o;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: got no response expected one within %0d cycles", name, budget);
        end
    endtask

    task automatic run_seq(output logic [199:0] s, output int hangs);
        logic       ok;
        logic [4:0] id;
        logic       h;
        s = '0; hangs = 0;
        do_reset();
        bus.enable_i = 1'b1;
        set_cfg(7'd50, 32'd1, 16'd0);
        bus.req_i = 8'h20;
        for (int k = 0; k < 200; k++) begin
            wait_resp(4, "repro_resp", ok, id, h);
            s[k]  = h;
            hangs += int'(h);
        end
        bus.req_i = '0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    initial begin : stim
        logic         ok;
        logic [4:0]   id;
        logic         h;
        int           hcnt;
        int           bcnt;
        int           nresp;
        int           diffs;
        int           hangs_a;
        int           hangs_b;
        logic [199:0] seq_a;
        logic [199:0] seq_b;

        bus.enable_i = 1'b0;
        bus.req_i    = '0;
        set_cfg(7'd0, 32'd0, 16'd0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;

        // Reset state
        chk("rst_resp_valid", bus.resp_valid_o, 1'b0);
        chk("rst_hang_o",     bus.hang_o,       '0);
        chk("rst_busy",       bus.busy_o,       1'b0);
        chk("rst_hang_count", bus.hang_count_o, 16'd0);

        // Single request: id 2, hang of 5, gap of 3
        bus.enable_i = 1'b1;
        set_cfg(7'd100, 32'd5, 16'd3);
        bus.req_i = 8'b0000_0100;
        wait_resp(3, "single_resp", ok, id, h);
        bus.req_i = '0;
        chk("single_id",   id, 5'd2);
        chk("single_hang", h,  1'b1);
        hcnt = 0; bcnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (i > 0) @(negedge clk_i);
            hcnt += int'(bus.hang_o[2]);
            bcnt += int'(bus.busy_o);
        end
        chk("single_hang_cycles", hcnt, 5);
        chk("single_busy_cycles", bcnt, 8);
        chk("single_hang_count",  bus.hang_count_o, 16'd1);

        // Round-robin across all links
        do_reset();
        bus.enable_i = 1'b1;
        set_cfg(7'd100, 32'd1, 16'd0);
        bus.req_i = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            wait_resp(4, "rr_resp", ok, id, h);
            chk("rr_id", id, 5'(k % N));
            bus.req_i = 8'hFF & ~(8'h01 << id);
            @(negedge clk_i);
            bus.req_i = 8'hFF;
        end
        bus.req_i = '0;

        // Never hang with zero chance
        do_reset();
        bus.enable_i = 1'b1;
        set_cfg(7'd0, 32'd10, 16'd2);
        nresp = 0; hcnt = 0;
        for (int k = 0; k < 10; k++) begin
            bus.req_i = 8'h08;
            wait_resp(3, "never_resp", ok, id, h);
            bus.req_i = '0;
            nresp += int'(ok);
            hcnt  += int'(h);
            @(negedge clk_i);
        end
        chk("never_resp_count", nresp, 10);
        chk("never_hangs",      hcnt,  0);
        chk("never_hang_count", bus.hang_count_o, 16'd0);

        // Abort: disable at hang cycle 10, no gap follows
        do_reset();
        bus.enable_i = 1'b1;
        set_cfg(7'd100, 32'd100, 16'd5);
        bus.req_i = 8'h01;
        wait_resp(3, "abort_resp", ok, id, h);
        bus.req_i = '0;
        repeat (9) @(negedge clk_i);
        chk("abort_hang_before", bus.hang_o, 8'h01);
        bus.enable_i = 1'b0;
        @(negedge clk_i);
        chk("abort_hang_cleared", bus.hang_o, 8'h00);
        chk("abort_busy_cleared", bus.busy_o, 1'b0);
        bus.enable_i = 1'b1;
        bus.req_i    = 8'h02;
        wait_resp(2, "abort_redecide", ok, id, h);
        bus.req_i = '0;
        chk("abort_redecide_id",   id, 5'd1);
        chk("abort_redecide_hang", h,  1'b1);

        // Zero cycles behaves as a one-cycle hang
        do_reset();
        bus.enable_i = 1'b1;
        set_cfg(7'd100, 32'd0, 16'd0);
        bus.req_i = 8'h40;
        wait_resp(3, "zero_resp", ok, id, h);
        bus.req_i = '0;
        hcnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk_i);
            hcnt += int'(bus.hang_o[6]);
        end
        chk("zero_hang_cycles", hcnt, 1);

        // Asynchronous reset mid-hang, then LFSR restored to SEED:
        // rolls are 0xACE1 % 100 = 57, then 0x5670 % 100 = 28.
        do_reset();
        bus.enable_i = 1'b1;
        set_cfg(7'd100, 32'd50, 16'd0);
        bus.req_i = 8'h01;
        wait_resp(3, "rstmid_resp", ok, id, h);
        bus.req_i = '0;
        repeat (3) @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rstmid_hang_async", bus.hang_o, 8'h00);
        chk("rstmid_busy_async", bus.busy_o, 1'b0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        set_cfg(7'd57, 32'd1, 16'd0);
        bus.req_i = 8'h10;
        wait_resp(1, "seed_roll0", ok, id, h);
        chk("seed_roll0_hang", h, 1'b0);
        wait_resp(1, "seed_roll1", ok, id, h);
        chk("seed_roll1_hang", h, 1'b1);
        chk("seed_roll1_id",   id, 5'd4);
        bus.req_i = '0;

        // Reproducibility over 200 decisions
        run_seq(seq_a, hangs_a);
        run_seq(seq_b, hangs_b);
        diffs = 0;
        for (int k = 0; k < 200; k++) if (seq_a[k] !== seq_b[k]) diffs++;
        chk("repro_diffs",   diffs, 0);
        chk("repro_hangs",   hangs_b, hangs_a);
        chk("repro_rate_ok", (hangs_a >= 70) && (hangs_a <= 130), 1'b1);

        repeat (3) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rs_hang_scheduler
`default_nettype wire
